// File: rtl/if_id_stage.sv
// if_id_stage: instruction fetch (PC, imem address) plus IF/ID pipeline register
//   clk_i, rst_n                      clock, async active-low reset
//   pc_hold_i, ifid_hold_i            hazard-unit freezes for PC and IF/ID
//   branch_taken_i, branch_target_i   EX-stage redirect (flushes IF/ID)
//   imem_addr_o, imem_data_i          instruction memory, combinational read
//   id_inst_o, id_pc_plus4_o, id_valid_o  IF/ID register towards decode
//   stall_cnt_o, flush_cnt_o          saturating performance counters
module if_id_stage #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              pc_hold_i,
  input  logic              ifid_hold_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [INST_W-1:0] imem_data_i,
  output logic [INST_W-1:0] id_inst_o,
  output logic [ADDR_W-1:0] id_pc_plus4_o,
  output logic              id_valid_o,
  output logic [15:0]       stall_cnt_o,
  output logic [15:0]       flush_cnt_o
);
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  assign pc_plus4    = pc + ADDR_W'(4);
  assign imem_addr_o = pc;
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      id_inst_o     <= '0;
      id_pc_plus4_o <= '0;
      id_valid_o    <= 1'b0;
      stall_cnt_o   <= '0;
      flush_cnt_o   <= '0;
    end else begin
      // branch wins over hold; target is forced word-aligned
      pc <= branch_taken_i ? {branch_target_i[ADDR_W-1:2], 2'b00} :
            pc_hold_i      ? pc : pc_plus4;
      // flush injects a NOP bubble without looking at imem_data_i
      if (branch_taken_i) begin
        id_inst_o     <= '0;
        id_pc_plus4_o <= '0;
        id_valid_o    <= 1'b0;
      end else if (!ifid_hold_i) begin
        id_inst_o     <= imem_data_i;
        id_pc_plus4_o <= pc_plus4;
        id_valid_o    <= 1'b1;
      end
      if (pc_hold_i && !branch_taken_i && stall_cnt_o != 16'hFFFF)
        stall_cnt_o <= stall_cnt_o + 16'd1;
      if (branch_taken_i && flush_cnt_o != 16'hFFFF)
        flush_cnt_o <= flush_cnt_o + 16'd1;
    end
  end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed and random checks of if_id_stage against a reference model
module tb_if_id_stage;
  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_hold_i = 1'b0;
  logic        ifid_hold_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] id_inst_o;
  logic [31:0] id_pc_plus4_o;
  logic        id_valid_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_inst, m_pc4;
  logic        m_valid;
  int          m_stall, m_flush;

  if_id_stage dut (
    .clk_i(clk_i), .rst_n(rst_n), .pc_hold_i(pc_hold_i), .ifid_hold_i(ifid_hold_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i), .id_inst_o(id_inst_o),
    .id_pc_plus4_o(id_pc_plus4_o), .id_valid_o(id_valid_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a >> 2) + 32'h100;
  endfunction

  assign imem_data_i = imem(imem_addr_o);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_inst = 0; m_pc4 = 0; m_valid = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".addr"},  64'(imem_addr_o),   64'(m_pc));
    chk({tag, ".inst"},  64'(id_inst_o),     64'(m_inst));
    chk({tag, ".pc4"},   64'(id_pc_plus4_o), 64'(m_pc4));
    chk({tag, ".valid"}, 64'(id_valid_o),    64'(m_valid));
    chk({tag, ".stall"}, 64'(stall_cnt_o),   64'(m_stall));
    chk({tag, ".flush"}, 64'(flush_cnt_o),   64'(m_flush));
  endtask

  // one clock edge; model follows the behavioural rules with the inputs held across the edge
  task automatic step();
    @(posedge clk_i);
    if (branch_taken_i) begin
      m_inst = 0; m_pc4 = 0; m_valid = 0;
      m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
      m_pc = branch_target_i & ~32'h3;
    end else begin
      if (!ifid_hold_i) begin
        m_inst = imem(m_pc); m_pc4 = m_pc + 4; m_valid = 1;
      end
      if (pc_hold_i) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      else m_pc = m_pc + 4;
    end
    #1;
  endtask

  task automatic drive(input logic ph, input logic ih, input logic br, input logic [31:0] tgt);
    pc_hold_i = ph; ifid_hold_i = ih; branch_taken_i = br; branch_target_i = tgt;
  endtask

  initial begin
    model_reset();
    #12;
    chk_all("reset");
    chk("reset.addr0", 64'(imem_addr_o), 64'h0);
    @(negedge clk_i);
    rst_n = 1'b1;
    #1;
    // 1: straight-line fetch
    step(); chk_all("seq1"); chk("seq1.inst", 64'(id_inst_o), 64'h100);
    step(); chk_all("seq2"); chk("seq2.addr", 64'(imem_addr_o), 64'h8);
    chk("seq2.inst", 64'(id_inst_o), 64'h101);
    // 2: double hold at PC=8
    drive(1, 1, 0, 0);
    step(); chk_all("hold1");
    step(); chk_all("hold2");
    chk("hold2.addr", 64'(imem_addr_o), 64'h8);
    chk("hold2.stall", 64'(stall_cnt_o), 64'd2);
    drive(0, 0, 0, 0);
    step(); chk_all("resume");
    chk("resume.inst", 64'(id_inst_o), 64'h102);
    chk("resume.addr", 64'(imem_addr_o), 64'hC);
    // 3: branch overrides pc hold
    drive(1, 0, 1, 32'h42);
    step(); chk_all("br");
    chk("br.addr", 64'(imem_addr_o), 64'h40);
    chk("br.valid", 64'(id_valid_o), 64'h0);
    chk("br.flush", 64'(flush_cnt_o), 64'd1);
    chk("br.stall", 64'(stall_cnt_o), 64'd2);
    drive(0, 0, 0, 0);
    step(); chk_all("brtgt");
    chk("brtgt.inst", 64'(id_inst_o), 64'h110);
    // random mix of holds and redirects
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0,
            ($urandom_range(3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(15))) : $urandom);
      step(); chk_all("rand");
    end
    // 4: PC wrap at top of address space (unaligned target also checks masking)
    drive(0, 0, 1, 32'hFFFFFFFF);
    step(); chk("wrap.top", 64'(imem_addr_o), 64'hFFFFFFFC);
    drive(0, 0, 0, 0);
    step(); chk_all("wrap");
    chk("wrap.addr", 64'(imem_addr_o), 64'h0);
    chk("wrap.pc4", 64'(id_pc_plus4_o), 64'h0);
    chk("wrap.valid", 64'(id_valid_o), 64'h1);
    // 5: stall counter saturation, then async reset mid-stall
    drive(1, 1, 0, 0);
    for (int i = 0; i < 70000; i++) step();
    chk_all("sat");
    chk("sat.stall", 64'(stall_cnt_o), 64'hFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst");
    drive(0, 0, 1, 32'h80);
    #20;
    chk_all("rst_hold");
    @(negedge clk_i);
    drive(0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    step(); chk_all("post_rst");
    chk("post_rst.inst", 64'(id_inst_o), 64'h100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
